backoff_counter: RTL

//  Per-AC backoff counter datapath driven by the backoff control FSM's load/enable strobes.

---
 rtl/backoff_counter.sv | 85 ++++++++
 1 files changed

// File: rtl/backoff_counter.sv
// Per-AC backoff slot counter: contention-window exponent tracking, LFSR-based
// random backoff draw, and per-slot decrement with an expiry pulse.
module backoff_counter #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [3:0]  CW_EXP_RST = 4'd4
) (
    input  logic        macCoreClk,
    input  logic        macCoreClkHardRst_n,
    input  logic        macCoreClkSoftRst_n,
    input  logic [3:0]  cwMin,
    input  logic [3:0]  cwMax,
    input  logic        backoffCntLoad,
    input  logic        backoffCntEnable,
    input  logic        tickSlot_p,
    input  logic        txFailed_p,
    input  logic        txSuccessful_p,
    input  logic        retryLTReached_p,
    input  logic        swCntWrEn,
    input  logic [15:0] swCntWrData,
    output logic [15:0] backoffCnt,
    output logic [3:0]  cwExp,
    output logic        backoffExpired_p
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned EXP_W = 4;
    localparam logic [CNT_W-1:0] LFSR_TAPS = 16'hB400;

    logic [CNT_W-1:0] lfsr;
    logic [CNT_W-1:0] lfsrNext_c;
    logic [EXP_W-1:0] cwMinEff_c;
    logic [EXP_W:0]   cwExpInc_c;
    logic [EXP_W-1:0] cwExpNext_c;
    logic [CNT_W-1:0] cwMask_c;
    logic [CNT_W-1:0] backoffCntNext_c;
    logic             expiredNext_c;

    // Next CW exponent; the failure path widens by one bit so 15+1 cannot wrap
    always_comb begin
        cwMinEff_c  = (cwMin < cwMax) ? cwMin : cwMax;
        cwExpInc_c  = (EXP_W+1)'(cwExp) + (EXP_W+1)'(1);
        cwExpNext_c = cwExp;
        if (txSuccessful_p || retryLTReached_p) begin
            cwExpNext_c = cwMinEff_c;
        end else if (txFailed_p) begin
            cwExpNext_c = (cwExpInc_c > (EXP_W+1)'(cwMax)) ? cwMax : EXP_W'(cwExpInc_c);
        end
        cwMask_c = CNT_W'((17'd1 << cwExpNext_c) - 17'd1);
    end

    // LFSR step and counter next-state; load uses this cycle's CW update
    always_comb begin
        lfsrNext_c       = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        backoffCntNext_c = backoffCnt;
        expiredNext_c    = 1'b0;
        if (swCntWrEn) begin
            backoffCntNext_c = swCntWrData;
        end else if (backoffCntLoad) begin
            backoffCntNext_c = lfsr & cwMask_c;
        end else if (backoffCntEnable && tickSlot_p && (backoffCnt != '0)) begin
            backoffCntNext_c = backoffCnt - CNT_W'(1);
            expiredNext_c    = (backoffCnt == CNT_W'(1));
        end
    end

    always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
        if (!macCoreClkHardRst_n) begin
            lfsr             <= LFSR_SEED;
            cwExp            <= CW_EXP_RST;
            backoffCnt       <= '0;
            backoffExpired_p <= 1'b0;
        end else if (!macCoreClkSoftRst_n) begin
            lfsr             <= LFSR_SEED;
            cwExp            <= CW_EXP_RST;
            backoffCnt       <= '0;
            backoffExpired_p <= 1'b0;
        end else begin
            lfsr             <= lfsrNext_c;
            cwExp            <= cwExpNext_c;
            backoffCnt       <= backoffCntNext_c;
            backoffExpired_p <= expiredNext_c;
        end
    end

endmodule
